rf_write_scheduler: RTL and testbench

Write-port scheduler for the 16×32 register file. It accepts destination-register writes from two requesters, the ALU writeback and the memory-load return, over valid/ready handshakes, and buffers one write per requester. Each cycle it grants at most one write onto the file's single write port (PW/RW/LE). It also sequences program-counter advance through PC_in/PCLd, so that a write to R15 (a branch) always takes precedence over the sequential PC update.

---
 rtl/rf_ctrl_pkg.sv | 23 ++
 rtl/rf_write_scheduler_wb_slot.sv | 25 ++
 rtl/rf_write_scheduler.sv | 114 +++++++++++
 tb/tb_rf_write_scheduler.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_ctrl_pkg.sv
// Shared constants and types for the register-file write scheduler.
// Holds the default widths, the PC register index and the buffered-write slot layout.
package rf_ctrl_pkg;

   localparam int WIDTH   = 32;
   localparam int PC_STEP = 4;

   localparam logic [3:0] REG_PC = 4'd15;

   localparam int REQ_ALU = 0;
   localparam int REQ_MEM = 1;

   typedef struct packed {
      logic             full;
      logic [3:0]       rd;
      logic [WIDTH-1:0] data;
   } slot_t;

   function automatic logic [15:0] rd_onehot(input slot_t s);
      return s.full ? (16'd1 << s.rd) : 16'd0;
   endfunction

endpackage

// File: rtl/rf_write_scheduler_wb_slot.sv
// One-entry writeback buffer: holds a single {rd, data} until it is drained.
// A load on the same edge as a drain refills the slot, so a stream never bubbles.
module wb_slot
   import rf_ctrl_pkg::*;
(
   input  logic             Clk,
   input  logic             Reset,
   input  logic             load,
   input  logic             drain,
   input  logic [3:0]       load_rd,
   input  logic [WIDTH-1:0] load_data,
   output slot_t            slot
);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         slot <= '0;
      end else if (load) begin
         slot <= '{full: 1'b1, rd: load_rd, data: load_data};
      end else if (drain) begin
         slot.full <= 1'b0;
      end
   end

endmodule

// File: rtl/rf_write_scheduler.sv
// Schedules ALU and load-return writes onto the single register-file write port
// and sequences PC advance so that a granted R15 write beats the sequential update.
module rf_write_scheduler #(
   parameter int WIDTH   = rf_ctrl_pkg::WIDTH,
   parameter int PC_STEP = rf_ctrl_pkg::PC_STEP
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             AluValid,
   input  logic [3:0]       AluRd,
   input  logic [WIDTH-1:0] AluData,
   output logic             AluReady,
   input  logic             MemValid,
   input  logic [3:0]       MemRd,
   input  logic [WIDTH-1:0] MemData,
   output logic             MemReady,
   input  logic             PcAdvance,
   input  logic [WIDTH-1:0] PcCur,
   output logic [WIDTH-1:0] PW,
   output logic [3:0]       RW,
   output logic             LE,
   output logic [WIDTH-1:0] PC_in,
   output logic             PCLd,
   output logic [15:0]      PendingMask
);

   import rf_ctrl_pkg::slot_t;
   import rf_ctrl_pkg::REG_PC;
   import rf_ctrl_pkg::REQ_ALU;
   import rf_ctrl_pkg::REQ_MEM;
   import rf_ctrl_pkg::rd_onehot;

   slot_t      alu_slot;
   slot_t      mem_slot;
   logic [1:0] grant;
   logic       mem_older;
   logic       alu_load;
   logic       mem_load;
   logic       alu_hold;
   logic       mem_hold;

   wb_slot u_alu_slot (
      .Clk       (Clk),
      .Reset     (Reset),
      .load      (alu_load),
      .drain     (grant[REQ_ALU]),
      .load_rd   (AluRd),
      .load_data (AluData),
      .slot      (alu_slot)
   );

   wb_slot u_mem_slot (
      .Clk       (Clk),
      .Reset     (Reset),
      .load      (mem_load),
      .drain     (grant[REQ_MEM]),
      .load_rd   (MemRd),
      .load_data (MemData),
      .slot      (mem_slot)
   );

   // With both slots occupied the older entry wins; otherwise whichever is full.
   always_comb begin
      grant = '0;
      if (alu_slot.full && mem_slot.full) begin
         grant[REQ_MEM] = mem_older;
         grant[REQ_ALU] = ~mem_older;
      end else begin
         grant[REQ_ALU] = alu_slot.full;
         grant[REQ_MEM] = mem_slot.full;
      end
   end

   assign AluReady = ~Reset & (~alu_slot.full | grant[REQ_ALU]);
   assign MemReady = ~Reset & (~mem_slot.full | grant[REQ_MEM]);
   assign alu_load = AluValid & AluReady;
   assign mem_load = MemValid & MemReady;

   assign alu_hold = alu_slot.full & ~grant[REQ_ALU];
   assign mem_hold = mem_slot.full & ~grant[REQ_MEM];

   // mem_older is the age bit: a held entry is older than a fresh one, and
   // simultaneous arrivals put Mem first so the ALU value lands last.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         mem_older <= 1'b0;
      end else if (alu_hold) begin
         mem_older <= mem_hold & mem_older;
      end else begin
         mem_older <= 1'b1;
      end
   end

   always_comb begin
      PW = '0;
      RW = '0;
      LE = 1'b0;
      if (grant[REQ_ALU]) begin
         PW = alu_slot.data;
         RW = alu_slot.rd;
         LE = 1'b1;
      end else if (grant[REQ_MEM]) begin
         PW = mem_slot.data;
         RW = mem_slot.rd;
         LE = 1'b1;
      end
   end

   // A branch write to R15 drops the sequential advance rather than deferring it.
   assign PC_in       = PcCur + WIDTH'(PC_STEP);
   assign PCLd        = ~Reset & PcAdvance & ~(LE && (RW == REG_PC));
   assign PendingMask = rd_onehot(alu_slot) | rd_onehot(mem_slot);

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Self-checking bench for rf_write_scheduler: directed scenarios then random traffic,
// compared against a ticket-ordered reference model and a small register-file model.
module tb_rf_write_scheduler;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        AluValid = 1'b0;
   logic [3:0]  AluRd = '0;
   logic [31:0] AluData = '0;
   logic        AluReady;
   logic        MemValid = 1'b0;
   logic [3:0]  MemRd = '0;
   logic [31:0] MemData = '0;
   logic        MemReady;
   logic        PcAdvance = 1'b0;
   logic [31:0] PcCur;
   logic [31:0] PW;
   logic [3:0]  RW;
   logic        LE;
   logic [31:0] PC_in;
   logic        PCLd;
   logic [15:0] PendingMask;

   logic [31:0] dut_rf [16];
   logic [31:0] model_rf [16];

   bit          alu_pend, mem_pend;
   logic [3:0]  alu_rd_m, mem_rd_m;
   logic [31:0] alu_data_m, mem_data_m;
   int          alu_tk, mem_tk, ticket;

   int          exp_grant;
   bit          exp_le, exp_pcld, exp_alu_ready, exp_mem_ready;
   logic [3:0]  exp_rw;
   logic [31:0] exp_pw, exp_pcin;
   logic [15:0] exp_mask;

   bit          alu_acc, mem_acc, alu_offer, mem_offer;
   int          checks = 0;
   int          failures = 0;

   assign PcCur = dut_rf[15];

   rf_write_scheduler dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .AluValid    (AluValid),
      .AluRd       (AluRd),
      .AluData     (AluData),
      .AluReady    (AluReady),
      .MemValid    (MemValid),
      .MemRd       (MemRd),
      .MemData     (MemData),
      .MemReady    (MemReady),
      .PcAdvance   (PcAdvance),
      .PcCur       (PcCur),
      .PW          (PW),
      .RW          (RW),
      .LE          (LE),
      .PC_in       (PC_in),
      .PCLd        (PCLd),
      .PendingMask (PendingMask)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // The oldest accepted write (lowest ticket) is the one the port should carry.
   task computeExpected;
      exp_grant = 0;
      if (alu_pend && mem_pend) exp_grant = (alu_tk < mem_tk) ? 1 : 2;
      else if (alu_pend)        exp_grant = 1;
      else if (mem_pend)        exp_grant = 2;
      exp_le   = (exp_grant != 0);
      exp_rw   = (exp_grant == 1) ? alu_rd_m : (exp_grant == 2) ? mem_rd_m : 4'd0;
      exp_pw   = (exp_grant == 1) ? alu_data_m : (exp_grant == 2) ? mem_data_m : 32'd0;
      exp_pcin = PcCur + 32'd4;
      exp_pcld = !Reset && PcAdvance && !(exp_le && exp_rw == 4'd15);
      exp_mask = (alu_pend ? (16'd1 << alu_rd_m) : 16'd0) | (mem_pend ? (16'd1 << mem_rd_m) : 16'd0);
      exp_alu_ready = !Reset && (!alu_pend || exp_grant == 1);
      exp_mem_ready = !Reset && (!mem_pend || exp_grant == 2);
   endtask

   task checkOutput;
      #1;
      computeExpected();
      check("LE", {31'd0, LE}, {31'd0, exp_le});
      check("RW", {28'd0, RW}, {28'd0, exp_rw});
      check("PW", PW, exp_pw);
      check("PCLd", {31'd0, PCLd}, {31'd0, exp_pcld});
      check("PC_in", PC_in, exp_pcin);
      check("PendingMask", {16'd0, PendingMask}, {16'd0, exp_mask});
      check("AluReady", {31'd0, AluReady}, {31'd0, exp_alu_ready});
      check("MemReady", {31'd0, MemReady}, {31'd0, exp_mem_ready});
   endtask

   task runCycle;
      logic        cap_le, cap_pcld;
      logic [3:0]  cap_rw;
      logic [31:0] cap_pw, cap_pcin;
      checkOutput();
      cap_le = LE; cap_rw = RW; cap_pw = PW; cap_pcld = PCLd; cap_pcin = PC_in;
      alu_acc = AluValid && exp_alu_ready;
      mem_acc = MemValid && exp_mem_ready;
      @(posedge Clk);
      #1;
      if (cap_le)   dut_rf[cap_rw] = cap_pw;
      if (cap_pcld) dut_rf[15] = cap_pcin;
      if (exp_le)   model_rf[exp_rw] = exp_pw;
      if (exp_pcld) model_rf[15] = exp_pcin;
      if (exp_grant == 1) alu_pend = 0;
      if (exp_grant == 2) mem_pend = 0;
      if (mem_acc) begin
         mem_pend = 1; mem_rd_m = MemRd; mem_data_m = MemData; mem_tk = ticket; ticket++;
      end
      if (alu_acc) begin
         alu_pend = 1; alu_rd_m = AluRd; alu_data_m = AluData; alu_tk = ticket; ticket++;
      end
      if (alu_acc) alu_offer = 0;
      if (mem_acc) mem_offer = 0;
      @(negedge Clk);
   endtask

   // Random requests are held stable until the handshake completes.
   task applyStimulus;
      if (!alu_offer && $urandom_range(0, 2) != 0) begin
         alu_offer = 1; AluRd = 4'($urandom_range(0, 15)); AluData = $urandom;
      end
      if (!mem_offer && $urandom_range(0, 2) != 0) begin
         mem_offer = 1; MemRd = 4'($urandom_range(0, 15)); MemData = $urandom;
      end
      AluValid  = alu_offer;
      MemValid  = mem_offer;
      PcAdvance = ($urandom_range(0, 3) == 0);
   endtask

   initial begin
      logic [3:0] prev_rw;
      int         alu_stall, mem_stall;
      for (int i = 0; i < 16; i++) begin
         dut_rf[i] = '0;
         model_rf[i] = '0;
      end
      ticket = 0;

      repeat (2) @(posedge Clk);
      @(negedge Clk);
      checkOutput();
      Reset = 1'b0;

      $display("[TB] single ALU write");
      AluValid = 1; AluRd = 4'd3; AluData = 32'hDEADBEEF;
      #1 check("t1_alu_ready", {31'd0, AluReady}, 32'd1);
      runCycle();
      AluValid = 0;
      #1;
      check("t1_le", {31'd0, LE}, 32'd1);
      check("t1_rw", {28'd0, RW}, 32'd3);
      check("t1_pw", PW, 32'hDEADBEEF);
      check("t1_mask", {16'd0, PendingMask}, 32'h0008);
      runCycle();
      #1;
      check("t1_le_off", {31'd0, LE}, 32'd0);
      check("t1_mask_off", {16'd0, PendingMask}, 32'd0);
      runCycle();

      $display("[TB] simultaneous same-Rd writes");
      AluValid = 1; AluRd = 4'd5; AluData = 32'h11;
      MemValid = 1; MemRd = 4'd5; MemData = 32'h22;
      runCycle();
      AluValid = 0; MemValid = 0;
      #1;
      check("t2_first_pw", PW, 32'h22);
      check("t2_mem_ready", {31'd0, MemReady}, 32'd1);
      check("t2_alu_ready", {31'd0, AluReady}, 32'd0);
      runCycle();
      #1 check("t2_second_pw", PW, 32'h11);
      runCycle();
      runCycle();
      check("t2_r5_final", dut_rf[5], 32'h11);

      $display("[TB] PC advance and wrap");
      AluValid = 1; AluRd = 4'd15; AluData = 32'h100;
      runCycle();
      AluValid = 0;
      runCycle();
      PcAdvance = 1;
      #1;
      check("t3_pc_in", PC_in, 32'h104);
      check("t3_pcld", {31'd0, PCLd}, 32'd1);
      runCycle();
      PcAdvance = 0;
      AluValid = 1; AluRd = 4'd15; AluData = 32'hFFFFFFFC;
      runCycle();
      AluValid = 0;
      runCycle();
      PcAdvance = 1;
      #1 check("t3_pc_wrap", PC_in, 32'd0);
      runCycle();
      PcAdvance = 0;

      $display("[TB] branch write beats PC advance");
      AluValid = 1; AluRd = 4'd15; AluData = 32'h400;
      runCycle();
      AluValid = 0; PcAdvance = 1;
      #1;
      check("t4_le", {31'd0, LE}, 32'd1);
      check("t4_rw", {28'd0, RW}, 32'd15);
      check("t4_pw", PW, 32'h400);
      check("t4_pcld", {31'd0, PCLd}, 32'd0);
      runCycle();
      PcAdvance = 0;
      #1 check("t4_pc_out", PcCur, 32'h400);

      $display("[TB] streaming from both requesters");
      AluRd = 4'd1; AluData = 32'h1000; MemRd = 4'd2; MemData = 32'h2000;
      alu_stall = 0; mem_stall = 0; prev_rw = '0;
      for (int i = 0; i < 10; i++) begin
         AluValid = 1; MemValid = 1;
         #1;
         if (i >= 1) check("t5_le", {31'd0, LE}, 32'd1);
         if (i >= 2) check("t5_alternate", {31'd0, RW != prev_rw}, 32'd1);
         prev_rw = RW;
         alu_stall = AluReady ? 0 : alu_stall + 1;
         mem_stall = MemReady ? 0 : mem_stall + 1;
         check("t5_alu_stall", {31'd0, alu_stall <= 1}, 32'd1);
         check("t5_mem_stall", {31'd0, mem_stall <= 1}, 32'd1);
         runCycle();
         if (alu_acc) AluData = AluData + 32'd1;
         if (mem_acc) MemData = MemData + 32'd1;
      end
      AluValid = 0; MemValid = 0;
      repeat (3) runCycle();

      $display("[TB] reset with both slots full");
      AluValid = 1; AluRd = 4'd7; AluData = 32'hA7;
      MemValid = 1; MemRd = 4'd8; MemData = 32'hB8;
      runCycle();
      AluValid = 0; MemValid = 0; PcAdvance = 1;
      #1 check("t6_le_before", {31'd0, LE}, 32'd1);
      Reset = 1;
      #1;
      check("t6_le", {31'd0, LE}, 32'd0);
      check("t6_pcld", {31'd0, PCLd}, 32'd0);
      check("t6_mask", {16'd0, PendingMask}, 32'd0);
      check("t6_alu_ready", {31'd0, AluReady}, 32'd0);
      alu_pend = 0; mem_pend = 0;
      @(posedge Clk);
      @(negedge Clk);
      Reset = 0; PcAdvance = 0;
      #1 check("t6_ready_after", {31'd0, AluReady & MemReady}, 32'd1);
      repeat (3) runCycle();

      $display("[TB] random traffic");
      alu_offer = 0; mem_offer = 0;
      for (int i = 0; i < 300; i++) begin
         applyStimulus();
         runCycle();
      end
      AluValid = 0; MemValid = 0; PcAdvance = 0;
      repeat (4) runCycle();

      for (int i = 0; i < 16; i++) check($sformatf("rf_r%0d", i), dut_rf[i], model_rf[i]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
